// File: rtl/univ_reg_pkg.sv
// Shared types and constants for the universal register.
package univ_reg_pkg;

    // Operation select, used only while en is high.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_UP   = 3'b100,
        MODE_DOWN = 3'b101,
        MODE_JK   = 3'b110,
        MODE_CPL  = 3'b111
    } mode_t;

    // Per-bit JK input pair, written as {j, k}.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Next value of a single JK flip-flop.
    function automatic logic jk_bit(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            JK_SET:    r = 1'b1;
            JK_RESET:  r = 1'b0;
            JK_TOGGLE: r = ~q;
            default:   r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/univ_reg_jk_next.sv
// Combinational next-value for the register's JK mode, one cell per bit.
module jk_next
    import univ_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q_next
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign q_next[gi] = jk_bit(q[gi], j[gi], k[gi]);
    end

endmodule

// File: rtl/univ_reg.sv
// Universal register: clear/set/load, shifts, rotate, modulo counter,
// complement and bitwise JK operation.
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             st,
    input  logic             ld,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             sout,
    output logic             tc
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] jk_val;

    jk_next #(.WIDTH(WIDTH)) u_jk_next (
        .q      (q_q),
        .j      (j),
        .k      (k),
        .q_next (jk_val)
    );

    // Next state: clr > st > ld > enabled mode > hold. tc defaults low so
    // it can only pulse for the single cycle after a counter wrap.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        tc_d   = 1'b0;
        if (st) begin
            q_d    = '1;
            sout_d = 1'b0;
        end else if (ld) begin
            q_d    = d;
            sout_d = 1'b0;
        end else if (en) begin
            case (mode_t'(mode))
                MODE_HOLD: q_d = q_q;
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], sin};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d    = {sin, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_UP: begin
                    // Values above MAX_VAL (from ld/st) also wrap to zero.
                    if (q_q >= MAX_VAL) begin
                        q_d  = '0;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (q_q == '0) begin
                        q_d  = MAX_VAL;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q - WIDTH'(1);
                    end
                end
                MODE_JK:  q_d = jk_val;
                MODE_CPL: q_d = ~q_q;
                default:  q_d = q_q;
            endcase
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_q    <= RST_VAL;
            sout_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
            tc_q   <= tc_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
    assign sout  = sout_q;
    assign tc    = tc_q;

endmodule
